ldtu_serial_word_aligner: RTL and testbench

Back-end receiver for one LiTE-DTU serializer output lane. It samples the serial bit stream on the serializer clock, finds the 32-bit word boundary by hunting for a sync/idle word, and confirms alignment over several consecutive sync words. It then delivers aligned 32-bit words with a valid strobe. It also watches for loss of alignment. One instance is used per serializer lane (four per DTU) in test benches and in the back-end emulation firmware.

---
 rtl/ldtu_serial_word_aligner.sv | 129 ++++++++++++
 tb/tb_ldtu_serial_word_aligner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_serial_word_aligner.sv
// Serial-lane word aligner for a LiTE-DTU serializer output: hunts for the sync
// word, confirms alignment over consecutive boundaries, then delivers aligned words.
module ldtu_serial_word_aligner #(
  parameter logic [31:0] SYNC_WORD = 32'hEAAA_EAAA,
  parameter int          CONFIRM_N = 4,
  parameter int          MAX_GAP   = 1024
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        serial_in,
  input  logic        realign,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        idle_word,
  output logic        locked,
  output logic        align_err
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0]  CONF_TARGET = 4'(CONFIRM_N);
  localparam logic [15:0] GAP_LIMIT   = 16'(MAX_GAP);

  state_t      state;
  logic [31:0] sr;
  logic [4:0]  bit_cnt;
  logic [3:0]  conf_cnt;
  logic [15:0] gap_cnt;
  logic        sync_hit;
  logic        boundary;

  assign sync_hit = (sr == SYNC_WORD);
  assign boundary = (bit_cnt == 5'd0);

  // Shift register, word phase counter and the hunt/confirm/locked state machine.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      sr         <= 32'h0;
      bit_cnt    <= 5'd0;
      conf_cnt   <= 4'd0;
      gap_cnt    <= 16'd0;
      data_out   <= 32'h0;
      data_valid <= 1'b0;
      idle_word  <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      sr         <= {sr[30:0], serial_in};
      bit_cnt    <= bit_cnt + 5'd1;
      data_valid <= 1'b0;
      idle_word  <= 1'b0;
      align_err  <= 1'b0;
      // realign wins over anything a simultaneous boundary would have done.
      if (realign) begin
        state    <= HUNT;
        conf_cnt <= 4'd0;
        gap_cnt  <= 16'd0;
        locked   <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              bit_cnt <= 5'd1;
              if (CONF_TARGET == 4'd1) begin
                state    <= LOCKED;
                conf_cnt <= 4'd0;
                gap_cnt  <= 16'd0;
                locked   <= 1'b1;
              end else begin
                state    <= CONFIRM;
                conf_cnt <= 4'd1;
              end
            end
          end
          CONFIRM: begin
            if (boundary) begin
              if (sync_hit) begin
                if ((conf_cnt + 4'd1) == CONF_TARGET) begin
                  state    <= LOCKED;
                  conf_cnt <= 4'd0;
                  gap_cnt  <= 16'd0;
                  locked   <= 1'b1;
                end else begin
                  conf_cnt <= conf_cnt + 4'd1;
                end
              end else begin
                state     <= HUNT;
                conf_cnt  <= 4'd0;
                align_err <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              data_out <= sr;
              if (sync_hit) begin
                idle_word <= 1'b1;
                gap_cnt   <= 16'd0;
              end else begin
                data_valid <= 1'b1;
                // Too many data words without an idle: the phase is no longer trusted.
                if ((gap_cnt + 16'd1) == GAP_LIMIT) begin
                  align_err <= 1'b1;
                  state     <= HUNT;
                  locked    <= 1'b0;
                  gap_cnt   <= 16'd0;
                end else begin
                  gap_cnt <= gap_cnt + 16'd1;
                end
              end
            end
          end
          default: begin
            state    <= HUNT;
            conf_cnt <= 4'd0;
            gap_cnt  <= 16'd0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldtu_serial_word_aligner.sv
// Scoreboard bench for ldtu_serial_word_aligner: a word-level reference model
// predicts every output event, a separate monitor compares what the DUT shows.
module tb_ldtu_serial_word_aligner;

  localparam logic [31:0] SYNC   = 32'hEAAA_EAAA;
  localparam int          CONF_N = 4;
  localparam int          GAP_N  = 4;

  logic        clock     = 1'b0;
  logic        rst       = 1'b1;
  logic        serial_in = 1'b0;
  logic        realign   = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        idle_word;
  logic        locked;
  logic        align_err;

  typedef struct {
    int          cyc;
    logic        v;
    logic        i;
    logic        e;
    logic        l;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  logic hist[$];
  int   mcyc;
  int   cyc;
  int   m_mode;
  int   m_nb;
  int   m_conf;
  int   m_gap;
  logic m_locked;
  int   vectors     = 0;
  int   miscompares = 0;
  logic done        = 1'b0;
  logic prev_l      = 1'b0;

  ldtu_serial_word_aligner #(
    .SYNC_WORD(SYNC),
    .CONFIRM_N(CONF_N),
    .MAX_GAP  (GAP_N)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .serial_in (serial_in),
    .realign   (realign),
    .data_out  (data_out),
    .data_valid(data_valid),
    .idle_word (idle_word),
    .locked    (locked),
    .align_err (align_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 32; k++) hist.push_back(1'b0);
    m_mode   = 0;
    m_nb     = 0;
    m_conf   = 0;
    m_gap    = 0;
    m_locked = 1'b0;
  endtask

  // Predict the edge about to happen from the last 32 received bits, then drive it.
  task automatic step(input logic b, input logic rl);
    int          n;
    logic [31:0] w;
    exp_t        e;
    n = mcyc + 1;
    for (int k = 0; k < 32; k++) w[31-k] = hist[hist.size()-32+k];
    e.cyc = n; e.v = 1'b0; e.i = 1'b0; e.e = 1'b0; e.d = w;
    case (m_mode)
      0: begin
        if (!rl && w == SYNC) begin
          m_mode = 1; m_conf = 1; m_nb = n + 32;
        end
      end
      1: begin
        if (rl) m_mode = 0;
        else if (n == m_nb) begin
          if (w == SYNC) begin
            m_conf = m_conf + 1;
            m_nb   = m_nb + 32;
            if (m_conf == CONF_N) begin
              m_mode = 2; m_gap = 0;
            end
          end else begin
            m_mode = 0; e.e = 1'b1;
          end
        end
      end
      2: begin
        if (rl) m_mode = 0;
        else if (n == m_nb) begin
          m_nb = m_nb + 32;
          if (w == SYNC) begin
            e.i = 1'b1; m_gap = 0;
          end else begin
            e.v = 1'b1; m_gap = m_gap + 1;
            if (m_gap == GAP_N) begin
              e.e = 1'b1; m_mode = 0;
            end
          end
        end
      end
      default: m_mode = 0;
    endcase
    e.l = (m_mode == 2);
    if (e.v || e.i || e.e || (e.l != m_locked)) q.push_back(e);
    m_locked = e.l;
    hist.push_back(b);
    if (hist.size() > 64) void'(hist.pop_front());
    serial_in = b;
    realign   = rl;
    @(posedge clock);
    mcyc = n;
    #1;
    realign = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd, input logic rl_first);
    for (int k = 0; k < 32; k++) step(wd[31-k], (k == 0) ? rl_first : 1'b0);
  endtask

  task automatic send_bits(input int cnt);
    logic rb;
    for (int k = 0; k < cnt; k++) begin
      rb = ($urandom_range(1, 0) != 0);
      step(rb, 1'b0);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1;
    rst  = 1'b0;
    mcyc = 0;
  endtask

  // Monitor: reset-state checks, then pop one expectation per observed DUT event.
  always @(negedge clock or posedge rst) begin
    exp_t e;
    if (rst) begin
      #1;
      prev_l  = 1'b0;
      vectors = vectors + 1;
      if (data_out !== 32'h0 || data_valid !== 1'b0 || idle_word !== 1'b0 ||
          locked !== 1'b0 || align_err !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL reset_state: data_out=%h dv=%b iw=%b lk=%b ae=%b, required all zero",
                 data_out, data_valid, idle_word, locked, align_err);
      end
    end else if (done) begin
      vectors = vectors + 1;
      if (q.size() != 0) begin
        miscompares = miscompares + 1;
        $display("FAIL missing_events: %0d predicted events never seen, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else if (data_valid !== 1'b0 || idle_word !== 1'b0 || align_err !== 1'b0 ||
                 locked !== prev_l) begin
      vectors = vectors + 1;
      if (q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL unexpected_event: cyc=%0d dv=%b iw=%b ae=%b lk=%b, required no event",
                 cyc, data_valid, idle_word, align_err, locked);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.v !== data_valid || e.i !== idle_word || e.e !== align_err ||
            e.l !== locked || ((e.v || e.i) && data_out !== e.d)) begin
          miscompares = miscompares + 1;
          $display("FAIL event: got cyc=%0d dv=%b iw=%b ae=%b lk=%b data=%h, required cyc=%0d dv=%b iw=%b ae=%b lk=%b data=%h",
                   cyc, data_valid, idle_word, align_err, locked, data_out,
                   e.cyc, e.v, e.i, e.e, e.l, e.d);
        end
      end
      prev_l = locked;
    end
  end

  initial begin
    logic [31:0] rw;
    model_reset();
    release_reset();

    // Continuous idle stream: lock, then regular idle_word pulses.
    repeat (8) send_word(SYNC, 1'b0);
    // One data word framed by idles.
    send_word(32'h1234_5678, 1'b0);
    repeat (2) send_word(SYNC, 1'b0);

    // Random mix of idles and data words.
    repeat (30) begin
      if ($urandom_range(2, 0) != 0) send_word(SYNC, 1'b0);
      else begin
        rw = $urandom;
        send_word(rw, 1'b0);
      end
    end
    repeat (6) send_word(SYNC, 1'b0);

    // One-bit slip while locked: lock must drop after GAP_N bad boundaries and recover.
    step(1'b0, 1'b0);
    repeat (14) send_word(SYNC, 1'b0);

    // realign on the boundary that delivers a data word.
    repeat (2) send_word(SYNC, 1'b0);
    send_word(32'hA5C3_0F96, 1'b0);
    send_word(SYNC, 1'b1);
    repeat (6) send_word(SYNC, 1'b0);

    // Asynchronous reset in the middle of a word while locked.
    rw = 32'h5A5A_5A5A;
    for (int k = 0; k < 13; k++) step(rw[31-k], 1'b0);
    #5;
    rst = 1'b1;
    model_reset();
    q.delete();
    release_reset();

    // False sync at an arbitrary phase followed by zeros, then a real sync stream.
    send_bits($urandom_range(31, 1));
    send_word(SYNC, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    repeat (8) send_word(SYNC, 1'b0);

    // More random traffic at a fresh phase.
    send_bits($urandom_range(31, 1));
    repeat (25) begin
      if ($urandom_range(1, 0) != 0) send_word(SYNC, 1'b0);
      else begin
        rw = $urandom;
        send_word(rw, 1'b0);
      end
    end
    repeat (5) send_word(SYNC, 1'b0);

    @(negedge clock);
    #1;
    done = 1'b1;
  end

endmodule
